// File: rtl/acc_cpu_param.sv
// Parametrised multi-cycle accumulator CPU: HALT/FETCH/EXEC control, internal imem/dmem, Z/C flags.
// Optional OUT port with valid/ready handshake is enabled by defining ACC_CPU_OUT_EN.
module acc_cpu_param #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [AW+3:0] prog_data,
  input  logic          start,
  output logic [AW-1:0] pc,
  output logic [DW-1:0] acc,
  output logic          zero,
  output logic          carry,
  output logic          halt
`ifdef ACC_CPU_OUT_EN
  ,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready
`endif
);
  localparam int IW    = 4 + AW;
  localparam int DEPTH = 1 << AW;

  localparam logic [3:0] OP_LDA = 4'h1, OP_STA = 4'h2, OP_ADD = 4'h3, OP_SUB = 4'h4,
                         OP_LDI = 4'h5, OP_JMP = 4'h6, OP_JZ  = 4'h7, OP_JC  = 4'h8,
                         OP_AND = 4'h9, OP_OR  = 4'hA, OP_XOR = 4'hB, OP_OUT = 4'hC,
                         OP_HLT = 4'hF;

  typedef enum logic [1:0] {S_HALT, S_FETCH, S_EXEC} state_t;

  state_t          state;
  logic [IW-1:0]   imem [DEPTH];
  logic [DW-1:0]   dmem [DEPTH];
  logic [IW-1:0]   ir;
  logic [IW-1:0]   fetch_word;
  logic [3:0]      op;
  logic [AW-1:0]   opr;
  logic [DW-1:0]   m;
  logic [DW:0]     sum, diff;
  logic [DW-1:0]   acc_n;
  logic            acc_we, c_n, stall;
  logic [AW-1:0]   pc_n;

  assign op         = ir[3:0];
  assign opr        = ir[IW-1:4];
  assign m          = dmem[opr];
  assign fetch_word = imem[pc];
  assign sum        = {1'b0, acc} + {1'b0, m};
  assign diff       = {1'b0, acc} - {1'b0, m};

`ifdef ACC_CPU_OUT_EN
  assign stall = (op == OP_OUT) && !out_ready;
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    acc_n  = acc;
    acc_we = 1'b0;
    c_n    = carry;
    pc_n   = pc + 1'b1;
    case (op)
      OP_LDA: begin acc_n = m; acc_we = 1'b1; end
      OP_ADD: begin {c_n, acc_n} = sum; acc_we = 1'b1; end
      OP_SUB: begin {c_n, acc_n} = diff; acc_we = 1'b1; end
      OP_LDI: begin acc_n = DW'(opr); acc_we = 1'b1; end
      OP_AND: begin acc_n = acc & m; acc_we = 1'b1; end
      OP_OR:  begin acc_n = acc | m; acc_we = 1'b1; end
      OP_XOR: begin acc_n = acc ^ m; acc_we = 1'b1; end
      OP_JMP: pc_n = opr;
      OP_JZ:  if (zero) pc_n = opr;
      OP_JC:  if (carry) pc_n = opr;
      default: ;
    endcase
  end

  // Program load only while halted; a write coinciding with start lands before the first FETCH.
  always_ff @(posedge clk) begin
    if (prog_we && halt) imem[prog_addr] <= prog_data;
  end

  always_ff @(posedge clk) begin
    if (!rst && state == S_EXEC && op == OP_STA) dmem[opr] <= acc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_HALT;
      pc    <= '0;
      acc   <= '0;
      zero  <= 1'b0;
      carry <= 1'b0;
      halt  <= 1'b1;
      ir    <= '0;
`ifdef ACC_CPU_OUT_EN
      out_valid <= 1'b0;
      out_data  <= '0;
`endif
    end else begin
      case (state)
        S_HALT: begin
          if (start) begin
            state <= S_FETCH;
            halt  <= 1'b0;
          end
        end
        S_FETCH: begin
          ir    <= fetch_word;
          state <= S_EXEC;
`ifdef ACC_CPU_OUT_EN
          // Raise valid as EXEC begins; acc cannot change during FETCH.
          if (fetch_word[3:0] == OP_OUT) begin
            out_valid <= 1'b1;
            out_data  <= acc;
          end
`endif
        end
        S_EXEC: begin
          if (!stall) begin
            pc    <= pc_n;
            acc   <= acc_n;
            carry <= c_n;
            if (acc_we) zero <= (acc_n == '0);
`ifdef ACC_CPU_OUT_EN
            out_valid <= 1'b0;
`endif
            if (op == OP_HLT) begin
              state <= S_HALT;
              halt  <= 1'b1;
            end else begin
              state <= S_FETCH;
            end
          end
        end
        default: state <= S_HALT;
      endcase
    end
  end
endmodule
